// File: rtl/somador_serial.sv
// Bit-serial adder: one full-add per clock, LSB first. The result register
// fills from its MSB end, so after N shifts the sum sits aligned in soma.
// Once valid is seen, soma/cout hold until the next start is accepted.
module somador_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         ack,
  output logic         ready,
  output logic         valid,
  output logic [N-1:0] soma,
  output logic         cout
);

  // state  | meaning
  // IDLE   | waiting for start; ready=1
  // SOMA   | one bit added per cycle, N cycles total
  // PRONTO | result held, valid=1 until ack

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SOMA   = 2'd1,
    PRONTO = 2'd2
  } state_t;

  state_t state, state_next;

  logic [N-1:0]  reg_a;
  logic [N-1:0]  reg_b;
  logic [N-1:0]  res;
  logic [N-1:0]  res_next;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          sum_bit;
  logic          carry_next;

  // Full add on the current LSBs, and the result shifted right with the new bit at its MSB
  always_comb begin
    sum_bit    = reg_a[0] ^ reg_b[0] ^ carry;
    carry_next = (reg_a[0] & reg_b[0]) | (reg_a[0] & carry) | (reg_b[0] & carry);
    res_next        = res >> 1;
    res_next[N-1]   = sum_bit;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; start only matters in IDLE, ack only in PRONTO
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SOMA;
      SOMA:    if (cnt == LAST) state_next = PRONTO;
      PRONTO:  if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on acceptance, shift/add in SOMA, hold everywhere else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a <= '0;
      reg_b <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            reg_a <= a;
            reg_b <= b;
            carry <= cin;
            res   <= '0;
            cnt   <= '0;
          end
        end
        SOMA: begin
          reg_a <= reg_a >> 1;
          reg_b <= reg_b >> 1;
          carry <= carry_next;
          res   <= res_next;
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake flags decode straight from the state; result comes from the registers
  always_comb begin
    ready = (state == IDLE);
    valid = (state == PRONTO);
    soma  = res;
    cout  = carry;
  end

endmodule

// File: tb/tb_somador_serial.sv
module tb_somador_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, cin8 = 1'b0, ack8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, valid8, cout8;
  logic [7:0] soma8;

  logic       start1 = 1'b0, cin1 = 1'b0, ack1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ready1, valid1, cout1;
  logic [0:0] soma1;

  int tests = 0;
  int fails = 0;

  somador_serial #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ack(ack8), .ready(ready8), .valid(valid8), .soma(soma8), .cout(cout8)
  );

  somador_serial #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .ack(ack1), .ready(ready1), .valid(valid1), .soma(soma1), .cout(cout1)
  );

  always #5 clk = ~clk;

  // Start an 8-bit add and wait for valid; reports edges after acceptance
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                     output int edges, output bit ready_low);
    @(negedge clk);
    a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    edges = 0;
    ready_low = (ready8 === 1'b0);
    while (valid8 !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (valid8 !== 1'b1 && ready8 !== 1'b0) ready_low = 1'b0;
    end
  endtask

  task automatic ack_8();
    @(negedge clk); ack8 = 1'b1;
    @(posedge clk); #1; ack8 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (ready8 !== 1'b1 || valid8 !== 1'b0 || soma8 !== 8'h00 || cout8 !== 1'b0) begin
      fails++;
      $display("FAIL reset: ready=%b valid=%b soma=%h cout=%b, want 1 0 00 0", ready8, valid8, soma8, cout8);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int e; bit rl;
    op8(8'h3C, 8'hA5, 1'b0, e, rl);
    tests++;
    if (e !== 8) begin fails++; $display("FAIL basic_latency: got %0d edges, want 8", e); end
    tests++;
    if (soma8 !== 8'hE1 || cout8 !== 1'b0) begin
      fails++; $display("FAIL basic_sum: soma=%h cout=%b, want e1 0", soma8, cout8);
    end
    tests++;
    if (!rl) begin fails++; $display("FAIL basic_ready: ready went high during SOMA"); end
    ack_8();
    tests++;
    if (ready8 !== 1'b1 || valid8 !== 1'b0 || soma8 !== 8'hE1) begin
      fails++; $display("FAIL basic_after_ack: ready=%b valid=%b soma=%h, want 1 0 e1", ready8, valid8, soma8);
    end
  endtask

  task automatic test_carry();
    int e; bit rl;
    op8(8'hFF, 8'h01, 1'b0, e, rl);
    tests++;
    if (soma8 !== 8'h00 || cout8 !== 1'b1) begin
      fails++; $display("FAIL carry_ff_01: soma=%h cout=%b, want 00 1", soma8, cout8);
    end
    ack_8();
    op8(8'hFF, 8'hFF, 1'b1, e, rl);
    tests++;
    if (soma8 !== 8'hFF || cout8 !== 1'b1) begin
      fails++; $display("FAIL carry_ff_ff_1: soma=%h cout=%b, want ff 1", soma8, cout8);
    end
    ack_8();
  endtask

  task automatic test_hold_pronto();
    int e; bit rl;
    op8(8'h55, 8'h0A, 1'b1, e, rl);
    tests++;
    if (valid8 !== 1'b1 || soma8 !== 8'h60 || cout8 !== 1'b0) begin
      fails++; $display("FAIL hold_result: valid=%b soma=%h cout=%b, want 1 60 0", valid8, soma8, cout8);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start8 = i[0]; a8 = 8'h11 * i[7:0]; b8 = ~a8; cin8 = ~i[0];
      @(posedge clk); #1;
      tests++;
      if (valid8 !== 1'b1 || soma8 !== 8'h60 || cout8 !== 1'b0) begin
        fails++; $display("FAIL hold_cycle%0d: valid=%b soma=%h cout=%b, want 1 60 0", i, valid8, soma8, cout8);
      end
    end
    @(negedge clk);
    start8 = 1'b1; ack8 = 1'b1; a8 = 8'hAA; b8 = 8'hAA;
    @(posedge clk); #1;
    start8 = 1'b0; ack8 = 1'b0;
    tests++;
    if (ready8 !== 1'b1 || valid8 !== 1'b0 || soma8 !== 8'h60 || cout8 !== 1'b0) begin
      fails++; $display("FAIL hold_ack_start: ready=%b valid=%b soma=%h cout=%b, want 1 0 60 0", ready8, valid8, soma8, cout8);
    end
    @(posedge clk); #1;
    tests++;
    if (ready8 !== 1'b1 || soma8 !== 8'h60) begin
      fails++; $display("FAIL hold_no_capture: ready=%b soma=%h, want 1 60", ready8, soma8);
    end
  endtask

  task automatic test_back_to_back();
    int e; bit rl;
    op8(8'h12, 8'h34, 1'b1, e, rl);
    tests++;
    if (soma8 !== 8'h47 || cout8 !== 1'b0 || !rl) begin
      fails++; $display("FAIL b2b_first: soma=%h cout=%b ready_low=%b, want 47 0 1", soma8, cout8, rl);
    end
    ack_8();
    op8(8'h80, 8'h80, 1'b0, e, rl);
    tests++;
    if (soma8 !== 8'h00 || cout8 !== 1'b1 || e !== 8) begin
      fails++; $display("FAIL b2b_second: soma=%h cout=%b edges=%0d, want 00 1 8", soma8, cout8, e);
    end
    tests++;
    if (!rl) begin fails++; $display("FAIL b2b_ready: ready went high during SOMA"); end
    ack_8();
  endtask

  task automatic test_async_reset();
    int e; bit rl;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (ready8 !== 1'b1 || valid8 !== 1'b0 || soma8 !== 8'h00 || cout8 !== 1'b0) begin
      fails++; $display("FAIL async_reset: ready=%b valid=%b soma=%h cout=%b, want 1 0 00 0", ready8, valid8, soma8, cout8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'h01, 8'h02, 1'b0, e, rl);
    tests++;
    if (soma8 !== 8'h03 || cout8 !== 1'b0 || e !== 8) begin
      fails++; $display("FAIL reset_recover: soma=%h cout=%b edges=%0d, want 03 0 8", soma8, cout8, e);
    end
    ack_8();
  endtask

  task automatic test_n1();
    int e;
    logic [1:0] tot;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      tot = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      e = 0;
      while (valid1 !== 1'b1 && e < 10) begin @(posedge clk); #1; e++; end
      tests++;
      if (e !== 1 || soma1 !== tot[0] || cout1 !== tot[1]) begin
        fails++;
        $display("FAIL n1_abc%b: soma=%b cout=%b edges=%0d, want %b %b 1", v, soma1, cout1, e, tot[0], tot[1]);
      end
      @(negedge clk); ack1 = 1'b1;
      @(posedge clk); #1; ack1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_hold_pronto();
    test_back_to_back();
    test_async_reset();
    test_n1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
